encoder_decoder_pipe: RTL
=========================

Name: encoder_decoder_pipe

Overview:
- Parametrised, pipelined round-trip encoder/decoder. Successor to the fixed 4-bit combinational encoder_decoder.
- Stage 1 encodes a WIDTH-bit binary word into a selectable code (binary, Gray, one-hot) and exposes the code word.
- Stage 2 decodes the code word back to binary and self-checks it against the original input.
- Valid/ready handshake on both sides. Intended for the datapath-exercise area and for code-conversion checks in larger blocks.

Parameters:
- WIDTH, 4, binary word width (1..8).
- CODE_W, 2**WIDTH, code word width. Must be at least 2**WIDTH so one-hot is representable.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- mode  in  2  code select, sampled with the word: 00 binary, 01 Gray, 10 one-hot, 11 reserved.
- binary_input  in  WIDTH  word to encode.
- code_valid  out  1  stage-1 register holds a word.
- code_word  out  CODE_W  stage-1 encoded word.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  consumer accepts the decoded word.
- binary_output  out  WIDTH  decoded word.
- mode_err  out  1  sticky flag: a word with mode 11 was accepted.
- chk_err  out  1  sticky flag: decoded word differed from its original input.
- xfer_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- Reset, on the rising clk edge with rst=1: code_valid=0, out_valid=0, code_word=0, binary_output=0, mode_err=0, chk_err=0, xfer_cnt=0.
- During reset, in_ready=0. Reset mid-operation discards all in-flight words, with no output handshake for them.
- Accept: a word is accepted when in_valid && in_ready. in_ready = !code_valid || s2_adv.
- Stage 2 advance: s2_adv = !out_valid || out_ready.
- Stage 1: on accept, register code_word, the mode and the original binary_input, and set code_valid=1.
- Stage 1 clears: code_valid falls when s2_adv and no new accept occurs.
- Stage 1 holds: when stage 2 is stalled, stage 1 holds all its registers, in_ready=0 if code_valid=1, and in_valid/mode/binary_input are ignored.
- Stage 2: on s2_adv && code_valid, register the decoded word, set out_valid=1 and compare it against the carried original word.
- Stage 2 clears: out_valid falls after an out_ready handshake if no new word arrives in that cycle.
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput: 1 word/cycle.
- Encodings: CODE_W bits; unused upper bits are 0.
  - Binary: code = b.
  - Gray: code = b ^ (b>>1).
  - One-hot: code = 1<<b.
  - Reserved (11): encoded and decoded as binary; sets mode_err.
- Decodes:
  - Gray: b[i] = XOR of code[WIDTH-1:i].
  - One-hot: index of the set bit. If zero bits or more than one bit is set, output 0 and set chk_err.
- chk_err and mode_err are sticky; only rst clears them.
- xfer_cnt increments on each out_valid && out_ready and wraps from 2**CNT_W-1 to 0.
- Simultaneous events: accept, stage-1-to-stage-2 move and output handshake may all occur in the same cycle with no bubble.

Optional Feature:
- Macro: ENC_DEC_PARITY_EN.
- When defined:
  - code_word widens to CODE_W+1 bits; the MSB is even parity over the lower CODE_W bits.
  - Stage 2 recomputes parity; a mismatch sets chk_err and forces binary_output=0 for that word.
  - An extra input port parity_flip (1 bit), sampled on accept, inverts the stored parity bit for error injection.
- When undefined: code_word is CODE_W bits, there is no parity check and no parity_flip port. All other behaviour is identical.

Test Plan:
- Gray sweep, WIDTH=4, mode=01, binary_input 0..15 on consecutive cycles, out_ready=1:
  - code_word follows 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8.
  - binary_output equals the input 2 cycles later.
  - xfer_cnt=16, chk_err=0.
- One-hot sweep, mode=10, inputs 0..15 -> code_word=1<<n (e.g. input 9 -> 0x0200), binary_output=n, chk_err=0.
- Backpressure: stream 0..7 in Gray with out_ready toggled 1,0,0,1,...:
  - No word lost or duplicated; output order 0..7.
  - in_ready=0 whenever both stages are full and out_ready=0.
- Reserved mode: one word 5 with mode=11 -> code_word=5, binary_output=5, mode_err=1 and stays 1 until rst.
- Reset mid-stream: assert rst for 1 cycle while both stages are valid:
  - Next cycle, out_valid=0, code_valid=0, xfer_cnt=0, flags 0.
  - A following word 3 emerges 2 cycles after accept.
- With ENC_DEC_PARITY_EN and CNT_W=4:
  - Word 6 with parity_flip=1 -> chk_err=1, binary_output=0.
  - 16 clean transfers -> xfer_cnt wraps to 0 (17 transfers total -> 1).

Source files
------------

// File: rtl/encoder_decoder_pipe.sv
// Two-stage pipelined round-trip encoder/decoder: stage 1 encodes (binary/Gray/one-hot),
// stage 2 decodes and self-checks. Optional parity on the code word: define ENC_DEC_PARITY_EN.
module encoder_decoder_pipe #(
  parameter int WIDTH  = 4,
  parameter int CODE_W = 2**WIDTH,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  binary_input,
`ifdef ENC_DEC_PARITY_EN
  input  logic              parity_flip,
  output logic [CODE_W:0]   code_word,
`else
  output logic [CODE_W-1:0] code_word,
`endif
  output logic              code_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  binary_output,
  output logic              mode_err,
  output logic              chk_err,
  output logic [CNT_W-1:0]  xfer_cnt
);

`ifdef ENC_DEC_PARITY_EN
  localparam int CW = CODE_W + 1;
`else
  localparam int CW = CODE_W;
`endif

  // Handshake: a transfer happens on a side in any cycle where its valid and ready are
  // both high at the rising edge; valid never depends on ready of the same side.
  logic              s2_adv;
  logic              accept;
  logic [CODE_W-1:0] enc;
  logic [CW-1:0]     enc_full;
  logic [1:0]        mode_q;
  logic [WIDTH-1:0]  orig_q;
  logic [WIDTH-1:0]  dec;
  logic              dec_err;
  logic              oh_seen;
  logic              oh_multi;
  logic              oh_high;
  logic [WIDTH-1:0]  oh_idx;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !rst && (!code_valid || s2_adv);
  assign accept   = in_valid && in_ready;

  always_comb begin
    enc = '0;
    case (mode)
      2'b01:   enc[WIDTH-1:0] = binary_input ^ (binary_input >> 1);
      2'b10:   enc = CODE_W'(1) << binary_input;
      default: enc[WIDTH-1:0] = binary_input;
    endcase
  end

`ifdef ENC_DEC_PARITY_EN
  assign enc_full = {(^enc) ^ parity_flip, enc};
`else
  assign enc_full = enc;
`endif

  always_comb begin
    dec      = '0;
    dec_err  = 1'b0;
    oh_seen  = 1'b0;
    oh_multi = 1'b0;
    oh_high  = 1'b0;
    oh_idx   = '0;
    // Set bits above 2**WIDTH-1 cannot name a valid word, so they count as a bad one-hot.
    for (int i = 0; i < CODE_W; i++) begin
      if (code_word[i]) begin
        if (oh_seen) oh_multi = 1'b1;
        oh_seen = 1'b1;
        if (i < (1 << WIDTH)) oh_idx = WIDTH'(i);
        else oh_high = 1'b1;
      end
    end
    case (mode_q)
      2'b01: begin
        for (int i = 0; i < WIDTH; i++) dec[i] = ^(code_word[WIDTH-1:0] >> i);
      end
      2'b10: begin
        if (oh_seen && !oh_multi && !oh_high) dec = oh_idx;
        else dec_err = 1'b1;
      end
      default: dec = code_word[WIDTH-1:0];
    endcase
`ifdef ENC_DEC_PARITY_EN
    if (code_word[CODE_W] != ^code_word[CODE_W-1:0]) begin
      dec     = '0;
      dec_err = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_valid    <= 1'b0;
      code_word     <= '0;
      mode_q        <= '0;
      orig_q        <= '0;
      out_valid     <= 1'b0;
      binary_output <= '0;
      mode_err      <= 1'b0;
      chk_err       <= 1'b0;
      xfer_cnt      <= '0;
    end else begin
      if (accept) begin
        code_word  <= enc_full;
        mode_q     <= mode;
        orig_q     <= binary_input;
        code_valid <= 1'b1;
        if (mode == 2'b11) mode_err <= 1'b1;
      end else if (s2_adv) begin
        code_valid <= 1'b0;
      end
      if (s2_adv) begin
        out_valid <= code_valid;
        if (code_valid) begin
          binary_output <= dec;
          if (dec_err || (dec != orig_q)) chk_err <= 1'b1;
        end
      end
      if (out_valid && out_ready) xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule
